// File: rtl/mips_16_pc_trace_buffer.sv
// PC trace buffer: captures {pc, instruction, timestamp} on PC change while RUN; halts on breakpoint.
// Circular buffer overwrites the oldest entry when full; one-cycle registered pop read.
`ifndef PC_WIDTH
`define PC_WIDTH 16
`endif

module mips_16_pc_trace_buffer #(
    parameter int PC_WIDTH    = `PC_WIDTH,
    parameter int INSTR_WIDTH = 16,
    parameter int DEPTH       = 16,
    parameter int TS_WIDTH    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PC_WIDTH-1:0]      pc,
    input  logic [INSTR_WIDTH-1:0]   instruction,
    input  logic                     trace_en,
    input  logic                     bp_en,
    input  logic [PC_WIDTH-1:0]      bp_addr,
    input  logic                     resume,
    input  logic                     clear,
    input  logic                     rd_req,
    output logic                     rd_valid,
    output logic [PC_WIDTH-1:0]      rd_pc,
    output logic [INSTR_WIDTH-1:0]   rd_instr,
    output logic [TS_WIDTH-1:0]      rd_ts,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     halt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t                  state_q, state_d;
    logic                    first_q;
    logic [PC_WIDTH-1:0]     last_pc_q;
    logic [TS_WIDTH-1:0]     ts_q;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    overflow_q, overflow_d;
    logic                    rd_valid_q;
    logic [PC_WIDTH-1:0]     rd_pc_q;
    logic [INSTR_WIDTH-1:0]  rd_instr_q;
    logic [TS_WIDTH-1:0]     rd_ts_q;

    logic [PC_WIDTH-1:0]     mem_pc    [DEPTH];
    logic [INSTR_WIDTH-1:0]  mem_instr [DEPTH];
    logic [TS_WIDTH-1:0]     mem_ts    [DEPTH];

    logic bp_hit, capture, cap_ok, pop_ok, full;

    assign bp_hit  = bp_en && (pc == bp_addr);
    assign capture = (state_q == RUN) && ((pc != last_pc_q) || first_q);
    assign cap_ok  = capture && !clear;
    assign pop_ok  = rd_req && (count_q != '0) && !clear;
    assign full    = (count_q == CW'(DEPTH));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (trace_en) state_d = RUN;
            RUN:     if (bp_hit) state_d = HALT;
                     else if (!trace_en) state_d = IDLE;
            HALT:    if (resume) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (cap_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
            if (cap_ok && !pop_ok) begin
                // Full buffer: drop the oldest entry to make room.
                if (full) begin
                    rd_ptr_d   = rd_ptr_q + 1'b1;
                    overflow_d = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else if (pop_ok && !cap_ok) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            first_q    <= 1'b0;
            last_pc_q  <= '0;
            ts_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_pc_q    <= '0;
            rd_instr_q <= '0;
            rd_ts_q    <= '0;
        end else begin
            state_q    <= state_d;
            first_q    <= (state_q == IDLE) && (state_d == RUN);
            last_pc_q  <= pc;
            ts_q       <= ts_q + 1'b1;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            rd_valid_q <= pop_ok;
            if (pop_ok) begin
                rd_pc_q    <= mem_pc[rd_ptr_q];
                rd_instr_q <= mem_instr[rd_ptr_q];
                rd_ts_q    <= mem_ts[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cap_ok) begin
            mem_pc[wr_ptr_q]    <= pc;
            mem_instr[wr_ptr_q] <= instruction;
            mem_ts[wr_ptr_q]    <= ts_q;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_pc    = rd_pc_q;
    assign rd_instr = rd_instr_q;
    assign rd_ts    = rd_ts_q;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign halt     = (state_q == HALT);
endmodule

// File: doc/mips_16_pc_trace_buffer.md
MIPS_16_PC_TRACE_BUFFER -- requirements
Module: mips_16_pc_trace_buffer

Interface
REQ-001 Parameter PC_WIDTH, default `PC_WIDTH, width of traced program counter.
REQ-002 Parameter INSTR_WIDTH, default 16, width of traced instruction word.
REQ-003 Parameter DEPTH, default 16, entries in trace buffer; SHALL be a power of two, >= 2.
REQ-004 Parameter TS_WIDTH, default 16, width of cycle timestamp stored per entry.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 pc  input  PC_WIDTH  core program counter being traced.
REQ-008 instruction  input  INSTR_WIDTH  instruction associated with pc in the same cycle.
REQ-009 trace_en  input  1  level enable for tracing.
REQ-010 bp_en  input  1  breakpoint compare enable.
REQ-011 bp_addr  input  PC_WIDTH  breakpoint PC.
REQ-012 resume  input  1  single-cycle pulse that leaves HALT.
REQ-013 clear  input  1  single-cycle synchronous buffer flush.
REQ-014 rd_req  input  1  pop request for oldest entry.
REQ-015 rd_valid  output  1  read data valid, one cycle per accepted pop.
REQ-016 rd_pc / rd_instr / rd_ts  output  PC_WIDTH / INSTR_WIDTH / TS_WIDTH  popped entry fields.
REQ-017 count  output  log2(DEPTH)+1  number of stored entries, 0..DEPTH.
REQ-018 overflow  output  1  sticky: at least one entry overwritten since last clear/reset.
REQ-019 halt  output  1  high while in HALT state (breakpoint hit).

Function
REQ-020 States IDLE, RUN, HALT; halt = (state == HALT).
REQ-021 IDLE -> RUN when trace_en=1; RUN -> IDLE when trace_en=0.
REQ-022 RUN -> HALT when bp_en=1 and pc==bp_addr; takes priority over trace_en=0 in the same cycle.
REQ-023 HALT -> IDLE on resume=1; resume in any other state has no effect; trace_en and bp_en are ignored in HALT.
REQ-024 Free-running timestamp counter increments every cycle, wraps modulo 2^TS_WIDTH.
REQ-025 Capture occurs in RUN when pc differs from the pc registered in the previous cycle, or on the first RUN cycle after entry from IDLE.
REQ-026 The breakpoint-matching cycle SHALL also capture if REQ-025 holds; no captures in IDLE or HALT.
REQ-027 Each capture stores {pc, instruction, current timestamp} at the write pointer, then the write pointer advances modulo DEPTH.
REQ-028 rd_req with count>0: next cycle rd_valid=1 with the oldest entry; read pointer advances; count decrements.
REQ-029 rd_req with count=0: ignored; rd_valid=0; no state change.
REQ-030 rd_valid and rd_* hold their last values, with rd_valid low, in cycles with no accepted pop.
REQ-031 Capture with count<DEPTH and no pop: count increments.
REQ-032 Capture with count==DEPTH and no pop: oldest entry overwritten; read pointer advances; count stays DEPTH; overflow set.
REQ-033 Capture and accepted pop in the same cycle: pop returns the pre-cycle oldest entry; count unchanged; overflow unchanged, including when full.
REQ-034 clear: pointers and count go to 0 and overflow clears next cycle; state, timestamp and last-pc are unaffected.
REQ-035 clear beats a same-cycle capture or pop: the capture is dropped, the pop is not accepted, and rd_valid=0.

Reset
REQ-036 rst=1 asynchronously forces: state IDLE, pointers 0, count 0, overflow 0, halt 0, rd_valid 0, rd_pc/rd_instr/rd_ts 0, timestamp 0, last-pc 0.
REQ-037 Reset mid-operation discards all stored entries; buffer RAM contents need not be cleared.

Verification
REQ-038 trace_en=1, pc steps 0,1,2,2,3 with instructions A0..A4 -> count=4; entries pc 0,1,2,3 with no duplicate for the repeated 2.
REQ-039 DEPTH=16, 20 distinct pcs captured with no reads -> count=16, overflow=1; the first pop returns the 5th captured pc.
REQ-040 Full buffer, rd_req held high while a new pc is captured -> count stays 16, overflow stays 0, rd_valid=1 with the oldest entry.
REQ-041 bp_en=1, bp_addr=5, pc runs 3,4,5,6 -> halt=1 the cycle after pc=5; entry 5 is captured, 6 is not. resume -> IDLE; trace_en=1 re-enters RUN and recaptures the current pc.
REQ-042 rd_req with count=0 -> rd_valid=0. clear with simultaneous capture -> count=0. rst asserted mid-trace -> all outputs 0 without waiting for a clock edge.
